// File: rtl/cipher_macro_shell_if.sv
// Handshake and core-facing bus of the cipher macro shell.
// The master side is the surrounding system plus the round core; the slave side is the shell itself.
interface cipher_macro_shell_if;
    logic         EN;
    logic         Krdy;
    logic [127:0] Kin;
    logic         Drdy;
    logic         EncDec;
    logic [63:0]  Din;
    logic         BSY;
    logic         Kvld;
    logic         Dvld;
    logic [63:0]  Dout;
    logic [127:0] KeyReg;
    logic         KeyStep;
    logic [6:0]   KeyCnt;
    logic         Dir;
    logic [3:0]   Rnd;
    logic [63:0]  State;
    logic [63:0]  NextState;

    modport master (
        output EN, Krdy, Kin, Drdy, EncDec, Din, NextState,
        input  BSY, Kvld, Dvld, Dout, KeyReg, KeyStep, KeyCnt, Dir, Rnd, State
    );

    modport slave (
        input  EN, Krdy, Kin, Drdy, EncDec, Din, NextState,
        output BSY, Kvld, Dvld, Dout, KeyReg, KeyStep, KeyCnt, Dir, Rnd, State
    );
endinterface

// File: rtl/cipher_macro_shell.sv
// Control shell around a block-cipher round core: sequences key-schedule cycles and data
// rounds, latches key/data/direction, and captures the final round result into Dout.
module cipher_macro_shell #(
    parameter int unsigned NROUND     = 16,
    parameter int unsigned KEY_CYCLES = 128
) (
    input logic                 CLK,
    input logic                 RSTn,
    cipher_macro_shell_if.slave bus
);
    typedef enum logic [1:0] {IDLE, KEY, DATA} fsm_t;

    localparam logic [6:0] KEY_LAST = 7'(KEY_CYCLES - 1);
    localparam logic [3:0] RND_LAST = 4'(NROUND - 1);

    fsm_t fsm, fsm_next;
    logic key_ok;
    logic load_key, load_data, key_done, data_done;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)       fsm <= IDLE;
        else if (bus.EN) fsm <= fsm_next;
    end

    // Krdy takes priority over Drdy in IDLE; requests in KEY/DATA are simply not looked at.
    always_comb begin
        fsm_next  = fsm;
        load_key  = 1'b0;
        load_data = 1'b0;
        key_done  = 1'b0;
        data_done = 1'b0;
        case (fsm)
            IDLE: begin
                if (bus.Krdy) begin
                    load_key = 1'b1;
                    fsm_next = KEY;
                end else if (bus.Drdy && key_ok) begin
                    load_data = 1'b1;
                    fsm_next  = DATA;
                end
            end
            KEY: begin
                if (bus.KeyCnt == KEY_LAST) begin
                    key_done = 1'b1;
                    fsm_next = IDLE;
                end
            end
            DATA: begin
                if (bus.Rnd == RND_LAST) begin
                    data_done = 1'b1;
                    fsm_next  = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    assign bus.BSY     = (fsm != IDLE);
    assign bus.KeyStep = (fsm == KEY);

    // Counters park on their terminal value once the phase ends; valid pulses are
    // registered so they simply hold while EN is low.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            key_ok     <= 1'b0;
            bus.Kvld   <= 1'b0;
            bus.Dvld   <= 1'b0;
            bus.Dout   <= '0;
            bus.State  <= '0;
            bus.KeyReg <= '0;
            bus.KeyCnt <= '0;
            bus.Rnd    <= '0;
            bus.Dir    <= 1'b0;
        end else if (bus.EN) begin
            bus.Kvld <= key_done;
            bus.Dvld <= data_done;
            if (load_key) begin
                bus.KeyReg <= bus.Kin;
                key_ok     <= 1'b0;
                bus.KeyCnt <= '0;
            end
            if (fsm == KEY && !key_done) bus.KeyCnt <= bus.KeyCnt + 7'd1;
            if (key_done) key_ok <= 1'b1;
            if (load_data) begin
                bus.State <= bus.Din;
                bus.Dir   <= bus.EncDec;
                bus.Rnd   <= '0;
            end
            if (fsm == DATA) begin
                bus.State <= bus.NextState;
                if (!data_done) bus.Rnd <= bus.Rnd + 4'd1;
            end
            if (data_done) bus.Dout <= bus.NextState;
        end
    end
endmodule
